// File: rtl/gigatron_pkg.sv
// Shared encodings for the Gigatron execute stage: instruction fields,
// condition codes, register widths and reset values.
package gigatron_pkg;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned ADDR_W = 16;

   localparam logic [DATA_W-1:0] REG_RST = 8'h00;

   typedef enum logic [2:0] {
      OP_LD  = 3'd0,
      OP_AND = 3'd1,
      OP_OR  = 3'd2,
      OP_XOR = 3'd3,
      OP_ADD = 3'd4,
      OP_SUB = 3'd5,
      OP_ST  = 3'd6,
      OP_BCC = 3'd7
   } op_e;

   typedef enum logic [2:0] {
      MODE_D_AC      = 3'd0,
      MODE_X_AC      = 3'd1,
      MODE_YD_AC     = 3'd2,
      MODE_YX_AC     = 3'd3,
      MODE_D_X       = 3'd4,
      MODE_D_Y       = 3'd5,
      MODE_D_OUT     = 3'd6,
      MODE_YXINC_OUT = 3'd7
   } mode_e;

   typedef enum logic [1:0] {
      SEL_D   = 2'd0,
      SEL_RAM = 2'd1,
      SEL_AC  = 2'd2,
      SEL_IN  = 2'd3
   } sel_e;

   // Branch conditions reuse the mode field of a Bcc instruction.
   typedef enum logic [2:0] {
      CC_JMP = 3'd0,
      CC_GT  = 3'd1,
      CC_LT  = 3'd2,
      CC_NE  = 3'd3,
      CC_EQ  = 3'd4,
      CC_GE  = 3'd5,
      CC_LE  = 3'd6,
      CC_BRA = 3'd7
   } cond_e;

   typedef struct packed {
      op_e   op;
      mode_e mode;
      sel_e  sel;
   } instr_t;

   function automatic instr_t decode(input logic [DATA_W-1:0] ir);
      return instr_t'(ir);
   endfunction

endpackage

// File: rtl/gigatron_alu.sv
// Combinational ALU and branch-condition evaluation for the execute stage.
module gigatron_alu
   import gigatron_pkg::*;
(
   input  op_e               op,
   input  cond_e             cc,
   input  logic [DATA_W-1:0] ac,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] result,
   output logic              cond
);

   logic ac_zero;
   logic ac_neg;

   assign ac_zero = (ac == REG_RST);
   assign ac_neg  = ac[DATA_W-1];

   // Stores and branches pass AC through unchanged.
   always_comb begin
      result = ac;
      case (op)
         OP_LD:   result = b;
         OP_AND:  result = ac & b;
         OP_OR:   result = ac | b;
         OP_XOR:  result = ac ^ b;
         OP_ADD:  result = DATA_W'(ac + b);
         OP_SUB:  result = DATA_W'(ac - b);
         default: result = ac;
      endcase
   end

   always_comb begin
      cond = 1'b0;
      case (cc)
         CC_JMP: cond = 1'b1;
         CC_GT:  cond = !ac_neg && !ac_zero;
         CC_LT:  cond = ac_neg;
         CC_NE:  cond = !ac_zero;
         CC_EQ:  cond = ac_zero;
         CC_GE:  cond = !ac_neg;
         CC_LE:  cond = ac_neg || ac_zero;
         CC_BRA: cond = 1'b1;
         default: cond = 1'b0;
      endcase
   end

endmodule

// File: rtl/gigatron_exec.sv
// Gigatron execute stage: decode, ALU, architectural registers, data-RAM
// port and shared-bus drivers; retires one instruction per clock.
module gigatron_exec
   import gigatron_pkg::*;
(
   input  logic              CLK,
   input  logic              RST,
   input  logic [DATA_W-1:0] IR,
   input  logic [DATA_W-1:0] D,
   inout  wire  [DATA_W-1:0] BUS,
   output logic              DE,
   output logic              PL,
   output logic              PH,
   output logic [DATA_W-1:0] Y,
   input  logic [DATA_W-1:0] IN,
   output logic [ADDR_W-1:0] RAM_A,
   input  logic [DATA_W-1:0] RAM_Q,
   output logic              RAM_WE,
   output logic [DATA_W-1:0] RAM_D,
   output logic [DATA_W-1:0] OUT,
   output logic [DATA_W-1:0] XOUT
);

   instr_t            ins;
   logic [DATA_W-1:0] ac_q, ac_d;
   logic [DATA_W-1:0] x_q, x_d;
   logic [DATA_W-1:0] y_q, y_d;
   logic [DATA_W-1:0] out_q, out_d;
   logic [DATA_W-1:0] xout_q, xout_d;
   logic              valid_q, valid_d;

   logic [DATA_W-1:0] bus_val;
   logic              bus_oe;
   logic [DATA_W-1:0] alu_res;
   logic              alu_cond;
   logic              is_st;
   logic              is_bcc;
   logic              commit;
   logic              reg_wr;

   assign ins    = decode(IR);
   assign is_st  = (ins.op == OP_ST);
   assign is_bcc = (ins.op == OP_BCC);
   // Side effects only once the flush cycle is over and reset is released.
   assign commit = valid_q && RST;

   gigatron_alu u_alu (
      .op     (ins.op),
      .cc     (cond_e'(ins.mode)),
      .ac     (ac_q),
      .b      (bus_val),
      .result (alu_res),
      .cond   (alu_cond)
   );

   // Data-RAM address; branches always address [0,D].
   always_comb begin
      RAM_A = {8'h00, D};
      if (!is_bcc) begin
         case (ins.mode)
            MODE_X_AC:                  RAM_A = {8'h00, x_q};
            MODE_YD_AC:                 RAM_A = {y_q, D};
            MODE_YX_AC, MODE_YXINC_OUT: RAM_A = {y_q, x_q};
            default:                    RAM_A = {8'h00, D};
         endcase
      end
   end

   always_comb begin
      bus_val = D;
      case (ins.sel)
         SEL_D:   bus_val = D;
         SEL_RAM: bus_val = RAM_Q;
         SEL_AC:  bus_val = ac_q;
         default: bus_val = IN;
      endcase
   end

   // The fetch stage drives D onto the bus itself when DE is high.
   assign bus_oe = (ins.sel != SEL_D);
   assign BUS    = bus_oe ? bus_val : {DATA_W{1'bz}};
   assign DE     = !bus_oe;

   assign RAM_D  = bus_val;
   assign RAM_WE = commit && is_st && (ins.sel != SEL_RAM);
   assign PL     = commit && is_bcc && ((cond_e'(ins.mode) == CC_JMP) || alu_cond);
   assign PH     = commit && is_bcc && (cond_e'(ins.mode) == CC_JMP);

   assign reg_wr = valid_q && !is_bcc && !(is_st && (ins.sel == SEL_RAM));

   always_comb begin
      ac_d    = ac_q;
      x_d     = x_q;
      y_d     = y_q;
      out_d   = out_q;
      xout_d  = xout_q;
      valid_d = 1'b1;
      if (reg_wr) begin
         case (ins.mode)
            MODE_D_AC, MODE_X_AC, MODE_YD_AC, MODE_YX_AC: begin
               if (!is_st) ac_d = alu_res;
            end
            MODE_D_X: x_d = alu_res;
            MODE_D_Y: y_d = alu_res;
            MODE_D_OUT: begin
               if (!is_st) out_d = alu_res;
            end
            default: begin
               if (!is_st) out_d = alu_res;
               x_d = DATA_W'(x_q + 8'd1);
            end
         endcase
      end
      // Rising edge of OUT[6] latches the outgoing AC into XOUT.
      if (out_d[6] && !out_q[6]) xout_d = ac_q;
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         ac_q    <= REG_RST;
         x_q     <= REG_RST;
         y_q     <= REG_RST;
         out_q   <= REG_RST;
         xout_q  <= REG_RST;
         valid_q <= 1'b0;
      end else begin
         ac_q    <= ac_d;
         x_q     <= x_d;
         y_q     <= y_d;
         out_q   <= out_d;
         xout_q  <= xout_d;
         valid_q <= valid_d;
      end
   end

   assign Y    = y_q;
   assign OUT  = out_q;
   assign XOUT = xout_q;

endmodule

// File: tb/tb_gigatron_exec.sv
// Bench for gigatron_exec: directed test-plan sequences with literal
// expectations, then randomized instructions against a behavioural model.
module tb_gigatron_exec;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic [7:0]  IR = 8'h00;
   logic [7:0]  D = 8'h00;
   logic [7:0]  IN = 8'h00;
   wire  [7:0]  BUS;
   logic        DE, PL, PH, RAM_WE;
   logic [7:0]  Y, RAM_Q, RAM_D, OUT, XOUT;
   logic [15:0] RAM_A;

   logic [7:0]  mem [0:65535];

   int checks = 0;
   int errors = 0;

   // behavioural model state
   logic [7:0]  m_ac, m_x, m_y, m_out, m_xout;
   logic        m_valid;
   // model expectations for the current cycle
   logic [2:0]  e_op, e_mode;
   logic [1:0]  e_sel;
   logic [15:0] e_a;
   logic [7:0]  e_b, e_res;
   logic        e_de, e_pl, e_ph, e_we;
   // DUT observations of the last stepped cycle
   logic [7:0]  last_bus;
   logic [15:0] last_a;
   logic        last_pl, last_ph, last_de, last_we;

   gigatron_exec dut (
      .CLK    (CLK),
      .RST    (RST),
      .IR     (IR),
      .D      (D),
      .BUS    (BUS),
      .DE     (DE),
      .PL     (PL),
      .PH     (PH),
      .Y      (Y),
      .IN     (IN),
      .RAM_A  (RAM_A),
      .RAM_Q  (RAM_Q),
      .RAM_WE (RAM_WE),
      .RAM_D  (RAM_D),
      .OUT    (OUT),
      .XOUT   (XOUT)
   );

   always #5 CLK = ~CLK;

   assign RAM_Q = mem[RAM_A];
   assign BUS   = DE ? D : 8'hzz;

   always @(posedge CLK) begin
      if (RAM_WE) mem[RAM_A] <= RAM_D;
   end

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // What the outputs must be this cycle, straight from the instruction table.
   task automatic model_comb();
      logic signed [7:0] s;
      logic              c;
      e_op   = IR[7:5];
      e_mode = IR[4:2];
      e_sel  = IR[1:0];
      if (e_op == 3'd7) e_a = {8'h00, D};
      else begin
         case (e_mode)
            3'd1:       e_a = {8'h00, m_x};
            3'd2:       e_a = {m_y, D};
            3'd3, 3'd7: e_a = {m_y, m_x};
            default:    e_a = {8'h00, D};
         endcase
      end
      case (e_sel)
         2'd0:    e_b = D;
         2'd1:    e_b = mem[e_a];
         2'd2:    e_b = m_ac;
         default: e_b = IN;
      endcase
      case (e_op)
         3'd0:    e_res = e_b;
         3'd1:    e_res = m_ac & e_b;
         3'd2:    e_res = m_ac | e_b;
         3'd3:    e_res = m_ac ^ e_b;
         3'd4:    e_res = 8'((int'(m_ac) + int'(e_b)) % 256);
         3'd5:    e_res = 8'((int'(m_ac) - int'(e_b) + 256) % 256);
         default: e_res = m_ac;
      endcase
      s = m_ac;
      case (e_mode)
         3'd1:    c = (s > 0);
         3'd2:    c = (s < 0);
         3'd3:    c = (s != 0);
         3'd4:    c = (s == 0);
         3'd5:    c = (s >= 0);
         3'd6:    c = (s <= 0);
         default: c = 1'b1;
      endcase
      e_de = (e_sel == 2'd0);
      e_pl = m_valid && RST && (e_op == 3'd7) && c;
      e_ph = m_valid && RST && (e_op == 3'd7) && (e_mode == 3'd0);
      e_we = m_valid && RST && (e_op == 3'd6) && (e_sel != 2'd1);
   endtask

   // Architectural effect of the clock edge.
   task automatic model_edge();
      logic [7:0] old_out;
      logic       st;
      if (!RST) begin
         m_ac = 8'h00; m_x = 8'h00; m_y = 8'h00; m_out = 8'h00; m_xout = 8'h00;
         m_valid = 1'b0;
         return;
      end
      st = (e_op == 3'd6);
      old_out = m_out;
      if (m_valid && e_op != 3'd7 && !(st && e_sel == 2'd1)) begin
         if (e_mode <= 3'd3 && !st) m_ac = e_res;
         if (e_mode == 3'd4) m_x = e_res;
         if (e_mode == 3'd5) m_y = e_res;
         if (e_mode >= 3'd6 && !st) m_out = e_res;
         if (e_mode == 3'd7) m_x = 8'((int'(m_x) + 1) % 256);
         if (m_out[6] && !old_out[6]) m_xout = m_ac;
      end
      m_valid = 1'b1;
   endtask

   // Runs one instruction: compare combinational outputs, clock, compare registers.
   task automatic step(input logic [7:0] ir, input logic [7:0] d);
      IR = ir;
      D  = d;
      #1;
      model_comb();
      chk("DE", {15'd0, DE}, {15'd0, e_de});
      chk("PL", {15'd0, PL}, {15'd0, e_pl});
      chk("PH", {15'd0, PH}, {15'd0, e_ph});
      chk("RAM_WE", {15'd0, RAM_WE}, {15'd0, e_we});
      chk("BUS", {8'd0, BUS}, {8'd0, e_b});
      if (e_op != 3'd7) chk("RAM_A", RAM_A, e_a);
      if (e_we) chk("RAM_D", {8'd0, RAM_D}, {8'd0, e_b});
      last_bus = BUS; last_a = RAM_A; last_pl = PL; last_ph = PH;
      last_de = DE; last_we = RAM_WE;
      @(posedge CLK);
      model_edge();
      @(negedge CLK);
      chk("Y", {8'd0, Y}, {8'd0, m_y});
      chk("OUT", {8'd0, OUT}, {8'd0, m_out});
      chk("XOUT", {8'd0, XOUT}, {8'd0, m_xout});
   endtask

   // AND AC with itself into AC: no side effect, AC visible on BUS.
   task automatic probe_ac(input string name, input logic [7:0] exp);
      step(8'h22, 8'h00);
      chk(name, {8'd0, last_bus}, {8'd0, exp});
   endtask

   // Same, but in [0,X] mode so X shows up on RAM_A.
   task automatic probe_x(input string name, input logic [7:0] exp);
      step(8'h26, 8'h00);
      chk(name, last_a, {8'h00, exp});
   endtask

   initial begin
      m_ac = 8'h00; m_x = 8'h00; m_y = 8'h00; m_out = 8'h00; m_xout = 8'h00;
      m_valid = 1'b0;
      for (int i = 0; i < 65536; i++) mem[i] <= 8'($urandom);
      @(negedge CLK);

      // reset and flush
      RST = 1'b0;
      step(8'h22, 8'h00);
      step(8'h22, 8'h00);
      chk("rst_out", {8'd0, OUT}, 16'h0000);
      chk("rst_y", {8'd0, Y}, 16'h0000);
      chk("rst_xout", {8'd0, XOUT}, 16'h0000);
      chk("rst_pl", {15'd0, last_pl}, 16'h0000);
      RST = 1'b1;
      step(8'h00, 8'h99);
      probe_ac("flush_ac", 8'h00);

      // arithmetic
      step(8'h00, 8'h5A);
      probe_ac("ld_5a", 8'h5A);
      step(8'h80, 8'hB0);
      probe_ac("add_b0", 8'h0A);
      step(8'hA0, 8'h0B);
      probe_ac("sub_0b", 8'hFF);

      // ld [Y,X++],OUT with wrap of X
      mem[16'h12FE] <= 8'h81;
      mem[16'h12FF] <= 8'h3C;
      step(8'h10, 8'hFE);
      step(8'h14, 8'h12);
      step(8'h1D, 8'h00);
      chk("out_81", {8'd0, OUT}, 16'h0081);
      probe_x("x_ff", 8'hFF);
      step(8'h1D, 8'h00);
      chk("out_3c", {8'd0, OUT}, 16'h003C);
      probe_x("x_wrap", 8'h00);

      // st [$34] from AC
      step(8'h00, 8'h77);
      step(8'hC2, 8'h34);
      chk("st_we", {15'd0, last_we}, 16'h0001);
      chk("st_a", last_a, 16'h0034);
      @(negedge CLK);
      chk("st_mem", {8'd0, mem[16'h0034]}, 16'h0077);
      probe_ac("st_ac", 8'h77);

      // conditional branches
      step(8'h00, 8'h80);
      step(8'hE8, 8'h20);
      chk("blt_pl", {15'd0, last_pl}, 16'h0001);
      chk("blt_ph", {15'd0, last_ph}, 16'h0000);
      step(8'hF4, 8'h20);
      chk("bge_pl", {15'd0, last_pl}, 16'h0000);
      step(8'h00, 8'h00);
      step(8'hF8, 8'h20);
      chk("ble_pl", {15'd0, last_pl}, 16'h0001);
      step(8'hE4, 8'h20);
      chk("bgt_pl", {15'd0, last_pl}, 16'h0000);

      // far jump with delay slot
      step(8'h14, 8'h03);
      chk("y_03", {8'd0, Y}, 16'h0003);
      step(8'hE0, 8'hC0);
      chk("jmp_pl", {15'd0, last_pl}, 16'h0001);
      chk("jmp_ph", {15'd0, last_ph}, 16'h0001);
      chk("jmp_bus", {8'd0, last_bus}, 16'h00C0);
      chk("jmp_de", {15'd0, last_de}, 16'h0001);
      step(8'h00, 8'h11);
      probe_ac("delay_slot", 8'h11);

      // XOUT capture on OUT[6] rising
      step(8'h18, 8'h00);
      step(8'h00, 8'h0F);
      step(8'h18, 8'h40);
      chk("xout_0f", {8'd0, XOUT}, 16'h000F);
      step(8'h00, 8'h33);
      step(8'h18, 8'hC0);
      chk("xout_hold", {8'd0, XOUT}, 16'h000F);

      // reset in the middle of a store
      step(8'h00, 8'h55);
      mem[16'h0050] <= 8'h00;
      RST = 1'b0;
      step(8'hC2, 8'h50);
      chk("rst_st_we", {15'd0, last_we}, 16'h0000);
      @(negedge CLK);
      chk("rst_st_mem", {8'd0, mem[16'h0050]}, 16'h0000);
      chk("rst_st_out", {8'd0, OUT}, 16'h0000);
      chk("rst_st_y", {8'd0, Y}, 16'h0000);
      chk("rst_st_xout", {8'd0, XOUT}, 16'h0000);
      RST = 1'b1;
      step(8'h00, 8'h99);
      probe_ac("rst_st_ac", 8'h00);

      // randomized instructions with occasional reset
      for (int n = 0; n < 1500; n++) begin
         RST = ($urandom_range(0, 59) != 0);
         IN  = 8'($urandom);
         step(8'($urandom), 8'($urandom));
      end
      RST = 1'b1;
      step(8'h22, 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/gigatron_exec.md
# gigatron_exec

Execute stage of the Gigatron CPU core. Consumes the instruction/data byte pair (IR, D) registered by the program-fetch stage each cycle, decodes it, runs the ALU, owns the architectural registers AC, X, Y, OUT, XOUT and the data-RAM port, drives the shared 8-bit BUS, and returns PL/PH/Y/DE to the fetch stage for jumps and immediate bus driving. One instruction retires per clock.

## Interface

Parameters:
- none

Ports:
- CLK  in  1  clock
- RST  in  1  reset, synchronous, active-low
- IR  in  8  instruction from fetch stage
- D  in  8  immediate/data byte from fetch stage
- BUS  inout  8  shared bus; driven here for bus sel RAM/AC/IN, else Z
- DE  out  1  fetch stage drives D onto BUS (bus sel = D)
- PL  out  1  load PC[7:0] from BUS at next edge
- PH  out  1  load PC[15:8] from Y at next edge
- Y  out  8  Y register (page for far jumps, RAM high address)
- IN  in  8  input port (controller)
- RAM_A  out  16  data-RAM address
- RAM_Q  in  8  data-RAM read data, combinational
- RAM_WE  out  1  data-RAM write strobe, written at CLK rising edge
- RAM_D  out  8  data-RAM write data (= BUS value)
- OUT  out  8  output register (video/sync)
- XOUT  out  8  extended output register (LEDs/audio)

## Operation

- Fields: op = IR[7:5] (0 LD,1 AND,2 OR,3 XOR,4 ADD,5 SUB,6 ST,7 Bcc); mode = IR[4:2]; sel = IR[1:0] (0 D,1 RAM,2 AC,3 IN).
- Bus value b: D (DE=1), RAM_Q, AC, or IN. Exactly one source drives BUS.
- ALU: LD b; AND AC&b; OR AC|b; XOR AC^b; ADD AC+b; SUB AC-b; ST passes AC. All 8-bit mod 256, no carry/flags.
- Non-jump modes (addr, destination): 0 [0,D]→AC; 1 [0,X]→AC; 2 [Y,D]→AC; 3 [Y,X]→AC; 4 [0,D]→X; 5 [0,D]→Y; 6 [0,D]→OUT; 7 [Y,X]→OUT, then X <= X+1 (wraps FF→00).
- ST: RAM_WE=1, RAM_D=b; AC and OUT not written; modes 4/5 still load X/Y with ALU output (AC). ST with sel=RAM: no RAM write, no register change.
- Bcc (op 7): target = b. mode 0 far jump: PL=PH=1 (PC <= {Y,b}). mode 1 gt (!AC[7]&&AC!=0), 2 lt (AC[7]), 3 ne, 4 eq, 5 ge (!AC[7]), 6 le (AC[7]||AC==0), 7 always: PL=cond, PH=0. No register writes.
- XOUT <= AC (pre-update) at any edge where OUT[6] goes 0→1.
- Flush: flag `valid` cleared while RST low, set one cycle after RST rises. While !valid: RAM_WE, PL, PH, all register writes suppressed; BUS still decoded.

## Timing

- Decode/ALU/bus combinational from IR, D, registers; all state updates on CLK rising edge.
- Register writes visible to the instruction in the following cycle (no bypass needed).
- Jump: PL/PH sampled by fetch at the same edge; the instruction already fetched behind the jump executes (one delay slot).
- Reset values: AC, X, Y, OUT, XOUT = 00; valid = 0; PL=PH=RAM_WE=0 during reset and the flush cycle.
- Reset asserted mid-operation: pending RAM write and PC load of that cycle are dropped.
- Simultaneous mode-7 OUT write and X++: both take effect same edge; address uses pre-increment X.

## Structure

- Package gigatron_pkg: op, mode, sel and condition encodings; reset constants.
- Sub-module gigatron_alu: combinational (op, AC, b) → result, plus condition evaluation.
- Top holds registers, address mux, BUS drivers, flush logic.

## Test plan

- Reset, then LD $5A (IR 00, D 5A) → AC=5A; ADD $B0 → AC=0A; SUB $0B → AC=FF.
- X=FE,Y=12, ST AC,[Y,X++]... i.e. IR=F3? use ld [Y,X++],OUT with RAM[12FE]=81 → OUT=81, X=FF; repeat → X=00 wrap.
- ST [$34] with AC=77, sel=AC → RAM_WE pulse, RAM_A=0034, RAM_D=77; AC unchanged.
- AC=80: blt $20 → PL=1, PH=0; bge $20 → PL=0; AC=00: ble taken, bgt not taken.
- Y=03, jmp Y,$C0 → PL=PH=1, BUS=C0 via DE; delay-slot instruction still executes.
- OUT 00→40 with AC=0F → XOUT=0F; OUT 40→C0 → XOUT unchanged; RST low mid-ST → no RAM write, all registers 00.
